cymometer_ctrl: RTL

Measurement sequencer for the direct-count frequency meter. It synchronises the external test signal `clk_fx` into the system clock domain and opens gate windows of programmable length. During each window it counts the rising edges of `clk_fx`, then scales the count to Hz and publishes it with a valid strobe. It supports single-shot and continuous measurement, and manual or automatic gate-range selection. It sits between the board-level signal input (or the on-chip dividers in simulation) and the display/readout logic.

---
 rtl/cymo_pkg.sv | 14 +
 rtl/cymo_if.sv | 22 ++
 rtl/cymo_edge_sync.sv | 14 +
 rtl/cymometer_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/cymo_pkg.sv
// cymo_pkg: shared state encoding, range/scale constants and result width for the frequency meter
package cymo_pkg;
    typedef enum logic [1:0] {IDLE, GATE, CALC, DONE} state_t;
    localparam logic [1:0] RANGE_L = 2'd0;
    localparam logic [1:0] RANGE_M = 2'd1;
    localparam logic [1:0] RANGE_S = 2'd2;
    localparam logic [6:0] SCALE_L = 7'd1;
    localparam logic [6:0] SCALE_M = 7'd10;
    localparam logic [6:0] SCALE_S = 7'd100;
    localparam int RES_W = 32;
    function automatic logic [6:0] range_scale(input logic [1:0] r);
        return r == RANGE_L ? SCALE_L : r == RANGE_M ? SCALE_M : SCALE_S;
    endfunction
endpackage

// File: rtl/cymo_if.sv
// cymo_if: control and result signals between the frequency meter and its host
interface cymo_if;
    import cymo_pkg::*;
    logic             start;
    logic             cont;
    logic             auto_range;
    logic [1:0]       range_sel;
    logic             gate;
    logic             busy;
    logic [RES_W-1:0] fre;
    logic             fre_vld;
    logic [1:0]       range_o;
    logic             ovf;
    modport master (
        output start, cont, auto_range, range_sel,
        input  gate, busy, fre, fre_vld, range_o, ovf
    );
    modport slave (
        input  start, cont, auto_range, range_sel,
        output gate, busy, fre, fre_vld, range_o, ovf
    );
endinterface

// File: rtl/cymo_edge_sync.sv
// cymo_edge_sync: 2-flop synchroniser plus edge register; one-cycle pulse per rising edge of async_in
module cymo_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);
    logic [2:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= 3'b000;
        else     sr <= {sr[1:0], async_in};
    end
    assign rise_pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/cymometer_ctrl.sv
// cymometer_ctrl: gated edge-count frequency meter with manual/auto range and continuous mode
module cymometer_ctrl
    import cymo_pkg::*;
#(
    parameter int unsigned GATE_CYC_L = 100_000_000,
    parameter int unsigned GATE_CYC_M = 10_000_000,
    parameter int unsigned GATE_CYC_S = 1_000_000,
    parameter int unsigned HI_TH      = 1_000_000,
    parameter int unsigned LO_TH      = 1_000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clk_fx,
    cymo_if.slave bus
);
    state_t           state, state_n;
    logic [1:0]       rng, rng_nxt, auto_rng, auto_nxt;
    logic [31:0]      gate_cnt, gate_len;
    logic [RES_W-1:0] cnt;
    logic [38:0]      prod;
    logic             cnt_ovf, prod_ovf, pulse, enter;
    cymo_edge_sync u_sync (.clk(clk), .rst(rst), .async_in(clk_fx), .rise_pulse(pulse));
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = (bus.start || bus.cont) ? GATE : IDLE;
            GATE: state_n = (gate_cnt == gate_len) ? CALC : GATE;
            CALC: state_n = DONE;
            DONE: state_n = bus.cont ? GATE : IDLE;
        endcase
    end
    assign enter    = (state_n == GATE) && (state != GATE);
    assign gate_len = rng == RANGE_L ? 32'(GATE_CYC_L) : rng == RANGE_M ? 32'(GATE_CYC_M) : 32'(GATE_CYC_S);
    assign rng_nxt  = bus.auto_range ? auto_rng : (bus.range_sel == 2'd3 ? RANGE_S : bus.range_sel);
    assign auto_nxt = (cnt > RES_W'(HI_TH) && rng < RANGE_S) ? rng + 2'd1 :
                      (cnt < RES_W'(LO_TH) && rng > RANGE_L) ? rng - 2'd1 : rng;
    assign prod     = 39'(cnt) * 39'(range_scale(rng));
    assign prod_ovf = |prod[38:RES_W];
    assign bus.gate    = state == GATE;
    assign bus.busy    = state != IDLE;
    assign bus.fre_vld = state == DONE;
    // the auto register is updated as DONE is entered so a continuous restart already sees it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rng         <= RANGE_L;
            auto_rng    <= RANGE_L;
            gate_cnt    <= '0;
            cnt         <= '0;
            cnt_ovf     <= 1'b0;
            bus.fre     <= '0;
            bus.range_o <= RANGE_L;
            bus.ovf     <= 1'b0;
        end else begin
            state <= state_n;
            if (enter) begin
                rng      <= rng_nxt;
                gate_cnt <= 32'd1;
                cnt      <= '0;
                cnt_ovf  <= 1'b0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt + 32'd1;
                if (pulse) begin
                    cnt     <= &cnt ? cnt : cnt + RES_W'(1);
                    cnt_ovf <= cnt_ovf | (&cnt);
                end
            end
            if (state == CALC) begin
                bus.fre     <= prod_ovf ? '1 : prod[RES_W-1:0];
                bus.range_o <= rng;
                bus.ovf     <= cnt_ovf | prod_ovf;
                if (bus.auto_range) auto_rng <= auto_nxt;
            end
        end
    end
endmodule
